inventory_scheduler: RTL and testbench

INVENTORY_SCHEDULER -- requirements
Module: inventory_scheduler

---
 rtl/inventory_pkg.sv | 21 ++
 rtl/inventory_scheduler_if.sv | 26 ++
 rtl/inventory_scheduler_exec_fifo.sv | 96 +++++++++
 rtl/inventory_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_inventory_scheduler.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inventory_pkg.sv
// Shared definitions for the inventory scheduler slice.
// Holds the default block parameters, the stock-id width derived from the
// default stock count, and the execution-queue entry type.
package inventory_pkg;

  localparam int DEF_FP_WORD_SIZE = 64;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_NUM_STOCKS   = 4;
  localparam int DEF_NUM_READERS  = 2;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_STARVE_LIMIT = 4;

  localparam int SIDW = $clog2(DEF_NUM_STOCKS);

  typedef struct packed {
    logic [SIDW-1:0]           stock_id;
    logic [DEF_DATA_WIDTH-1:0] qty;
    logic                      side;      // 0 buy, 1 sell
  } exec_entry_t;

endpackage

// File: rtl/inventory_scheduler_if.sv
// Execution input handshake for the inventory scheduler.
//   master : drives i_exec_valid, i_exec_stock_id, i_exec_qty, i_exec_side;
//            observes o_exec_ready
//   slave  : the scheduler side, drives o_exec_ready
interface inventory_scheduler_if
  import inventory_pkg::*;
#(
  parameter int SID_W      = SIDW,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  i_exec_valid;
  logic                  o_exec_ready;
  logic [SID_W-1:0]      i_exec_stock_id;
  logic [DATA_WIDTH-1:0] i_exec_qty;
  logic                  i_exec_side;

  modport master (
    output i_exec_valid, i_exec_stock_id, i_exec_qty, i_exec_side,
    input  o_exec_ready
  );

  modport slave (
    input  i_exec_valid, i_exec_stock_id, i_exec_qty, i_exec_side,
    output o_exec_ready
  );
endinterface

// File: rtl/inventory_scheduler_exec_fifo.sv
// exec_fifo: synchronous execution queue for the inventory scheduler.
// Ports:
//   i_clk, i_reset_n        clock, synchronous active-low reset (empties queue)
//   i_push, i_push_entry    enqueue request (ignored when full)
//   i_pop                   dequeue request (ignored when empty)
//   o_head                  entry at the head of the queue
//   o_empty, o_full         occupancy flags
//   o_slot_sid, o_slot_valid  per-slot stock ids and occupancy, used by the
//                           scheduler's read-after-execution hazard check
module exec_fifo
  import inventory_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_push,
  input  exec_entry_t            i_push_entry,
  input  logic                   i_pop,
  output exec_entry_t            o_head,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [DEPTH*SIDW-1:0]  o_slot_sid,
  output logic [DEPTH-1:0]       o_slot_valid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  exec_entry_t   mem_q [DEPTH];
  exec_entry_t   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_head  = mem_q[rd_ptr_q];
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_push_entry;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A slot is occupied when its distance from the read pointer (modulo the
  // depth) is below the current count.
  always_comb begin : slot_p
    int off;
    off          = 0;
    o_slot_sid   = '0;
    o_slot_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = (i + DEPTH - int'(rd_ptr_q)) % DEPTH;
      o_slot_valid[i]            = (off < int'(count_q));
      o_slot_sid[i*SIDW +: SIDW] = mem_q[i].stock_id;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/inventory_scheduler.sv
// inventory_scheduler: arbitrates a shared inventory port between queued
// order executions (WRITE) and pricing readers (READ), one operation per
// cycle.
// Ports:
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   exec_if (slave)           execution handshake: valid/ready, stock, qty, side
//   i_cfg_we, i_cfg_max_inv_recip, o_cfg_ready
//                             reciprocal register load, only while idle
//   i_rd_req, i_rd_stock_id, o_rd_grant, o_rd_valid, o_rd_data
//                             reader requests, grants and registered responses
//   o_inv_*, i_inv_norm_inventory
//                             inventory-side command and combinational read data
module inventory_scheduler
  import inventory_pkg::*;
#(
  parameter int FP_WORD_SIZE = DEF_FP_WORD_SIZE,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_STOCKS   = DEF_NUM_STOCKS,
  parameter int NUM_READERS  = DEF_NUM_READERS,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  localparam int SID_W       = $clog2(NUM_STOCKS)
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  inventory_scheduler_if.slave           exec_if,
  input  logic                           i_cfg_we,
  input  logic [FP_WORD_SIZE-1:0]        i_cfg_max_inv_recip,
  output logic                           o_cfg_ready,
  input  logic [NUM_READERS-1:0]         i_rd_req,
  input  logic [NUM_READERS*SID_W-1:0]   i_rd_stock_id,
  output logic [NUM_READERS-1:0]         o_rd_grant,
  output logic [NUM_READERS-1:0]         o_rd_valid,
  output logic signed [FP_WORD_SIZE-1:0] o_rd_data,
  output logic                           o_inv_ren,
  output logic [SID_W-1:0]               o_inv_stock_id,
  output logic [FP_WORD_SIZE-1:0]        o_inv_max_inv_recip,
  output logic                           o_inv_exec,
  output logic [DATA_WIDTH-1:0]          o_inv_exec_qty,
  output logic                           o_inv_exec_side,
  input  logic signed [FP_WORD_SIZE-1:0] i_inv_norm_inventory
);

  localparam int RW  = (NUM_READERS > 1) ? $clog2(NUM_READERS) : 1;
  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  exec_entry_t                   push_entry;
  exec_entry_t                   head;
  logic                          fifo_empty, fifo_full;
  logic [FIFO_DEPTH*SIDW-1:0]    slot_sid;
  logic [FIFO_DEPTH-1:0]         slot_valid;
  logic                          push;

  logic [SID_W-1:0]              rd_sid [NUM_READERS];
  logic [NUM_READERS-1:0]        eligible;
  logic                          any_elig;
  logic [RW-1:0]                 grant_idx;
  logic                          do_read, do_write;

  logic [SCW-1:0]                starve_q, starve_d;
  logic [RW-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [FP_WORD_SIZE-1:0]       recip_q, recip_d;
  logic [NUM_READERS-1:0]        rd_valid_q, rd_valid_d;
  logic signed [FP_WORD_SIZE-1:0] rd_data_q, rd_data_d;

  // No pop-bypass: a full queue refuses a push even in a cycle that pops.
  assign exec_if.o_exec_ready = ~fifo_full;
  assign push                 = exec_if.i_exec_valid & ~fifo_full;

  always_comb begin
    push_entry          = '0;
    push_entry.stock_id = exec_if.i_exec_stock_id;
    push_entry.qty      = exec_if.i_exec_qty;
    push_entry.side     = exec_if.i_exec_side;
  end

  exec_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_exec_fifo (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_push       (push),
    .i_push_entry (push_entry),
    .i_pop        (do_write),
    .o_head       (head),
    .o_empty      (fifo_empty),
    .o_full       (fifo_full),
    .o_slot_sid   (slot_sid),
    .o_slot_valid (slot_valid)
  );

  // A reader waits while any queued execution (head included) still targets
  // its stock, so it always observes inventory after those executions.
  always_comb begin : elig_p
    logic blocked;
    blocked  = 1'b0;
    eligible = '0;
    for (int k = 0; k < NUM_READERS; k++) begin
      rd_sid[k] = i_rd_stock_id[k*SID_W +: SID_W];
      blocked   = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (slot_valid[i] && (slot_sid[i*SIDW +: SIDW] == rd_sid[k])) blocked = 1'b1;
      end
      eligible[k] = i_rd_req[k] & ~blocked;
    end
  end

  assign any_elig = |eligible;

  // Round-robin search starting at the pointer.
  always_comb begin : rr_p
    logic found;
    found     = 1'b0;
    grant_idx = '0;
    for (int n = 0; n < NUM_READERS; n++) begin
      int idx;
      idx = (int'(rr_ptr_q) + n) % NUM_READERS;
      if (!found && eligible[idx]) begin
        found     = 1'b1;
        grant_idx = RW'(idx);
      end
    end
  end

  // Writes win unless a read has been passed over STARVE_LIMIT times.
  assign do_read  = any_elig & (fifo_empty | (starve_q == SCW'(STARVE_LIMIT)));
  assign do_write = ~fifo_empty & ~do_read;

  always_comb begin
    starve_d = '0;
    if (do_write && any_elig) begin
      starve_d = (starve_q == SCW'(STARVE_LIMIT)) ? starve_q : starve_q + SCW'(1);
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (do_read) begin
      rr_ptr_d = (int'(grant_idx) == NUM_READERS - 1) ? '0 : grant_idx + RW'(1);
    end
  end

  always_comb begin
    o_rd_grant = '0;
    for (int k = 0; k < NUM_READERS; k++) begin
      o_rd_grant[k] = do_read && (int'(grant_idx) == k);
    end
  end

  always_comb begin
    o_inv_ren       = do_read;
    o_inv_exec      = do_write;
    o_inv_stock_id  = '0;
    o_inv_exec_qty  = '0;
    o_inv_exec_side = 1'b0;
    if (do_read) begin
      o_inv_stock_id = rd_sid[grant_idx];
    end else if (do_write) begin
      o_inv_stock_id  = head.stock_id;
      o_inv_exec_qty  = head.qty;
      o_inv_exec_side = head.side;
    end
  end

  always_comb begin
    rd_valid_d = o_rd_grant;
    rd_data_d  = do_read ? i_inv_norm_inventory : rd_data_q;
  end

  // Reconfiguring the reciprocal is only safe with nothing queued or arriving.
  assign o_cfg_ready = fifo_empty & ~push;

  always_comb begin
    recip_d = (i_cfg_we && o_cfg_ready) ? i_cfg_max_inv_recip : recip_q;
  end

  assign o_inv_max_inv_recip = recip_q;
  assign o_rd_valid          = rd_valid_q;
  assign o_rd_data           = rd_data_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      starve_q   <= '0;
      rr_ptr_q   <= '0;
      recip_q    <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      rr_ptr_q   <= rr_ptr_d;
      recip_q    <= recip_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_inventory_scheduler.sv
// Self-checking bench for inventory_scheduler: a per-cycle vector table for
// the single-step behaviour plus hand-written starvation, reset and
// round-robin sequences.
module tb_inventory_scheduler;
  import inventory_pkg::*;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  always #5 i_clk = ~i_clk;

  inventory_scheduler_if ex_if ();

  logic        cfg_we;
  logic [63:0] cfg_val;
  logic        cfg_ready;
  logic [1:0]  rd_req;
  logic [3:0]  rd_sid;
  logic [1:0]  rd_grant;
  logic [1:0]  rd_valid;
  logic signed [63:0] rd_data;
  logic        inv_ren;
  logic [1:0]  inv_sid;
  logic [63:0] recip;
  logic        inv_exec;
  logic [31:0] inv_qty;
  logic        inv_side;
  logic signed [63:0] inv_data;

  // Inventory model: data reflects the stock being read.
  assign inv_data = {48'hCAFE_0000_0000, 14'd0, inv_sid};

  inventory_scheduler dut (
    .i_clk                (i_clk),
    .i_reset_n            (i_reset_n),
    .exec_if              (ex_if),
    .i_cfg_we             (cfg_we),
    .i_cfg_max_inv_recip  (cfg_val),
    .o_cfg_ready          (cfg_ready),
    .i_rd_req             (rd_req),
    .i_rd_stock_id        (rd_sid),
    .o_rd_grant           (rd_grant),
    .o_rd_valid           (rd_valid),
    .o_rd_data            (rd_data),
    .o_inv_ren            (inv_ren),
    .o_inv_stock_id       (inv_sid),
    .o_inv_max_inv_recip  (recip),
    .o_inv_exec           (inv_exec),
    .o_inv_exec_qty       (inv_qty),
    .o_inv_exec_side      (inv_side),
    .i_inv_norm_inventory (inv_data)
  );

  localparam logic [63:0] R  = 64'h0000_0000_028F_5C29;
  localparam logic [63:0] C  = 64'hCAFE_0000_0000_0000;
  localparam logic [63:0] K1 = 64'h0000_0000_0000_1111;
  localparam logic [63:0] KF = 64'hFFFF_FFFF_FFFF_FFFF;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  typedef struct packed {
    logic        ev;
    logic [1:0]  esid;
    logic [31:0] eqty;
    logic        eside;
    logic [1:0]  rreq;
    logic [1:0]  rsid0;
    logic [1:0]  rsid1;
    logic        cwe;
    logic [63:0] cval;
    logic        x_rdy;
    logic        x_exec;
    logic        x_ren;
    logic [1:0]  x_sid;
    logic [31:0] x_qty;
    logic        x_side;
    logic [1:0]  x_grant;
    logic [1:0]  x_rvalid;
    logic [63:0] x_rdata;
    logic        x_cfg_rdy;
    logic [63:0] x_recip;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic ev, input logic [1:0] esid, input logic [31:0] eqty, input logic eside,
    input logic [1:0] rreq, input logic [1:0] rsid0, input logic [1:0] rsid1,
    input logic cwe, input logic [63:0] cval,
    input logic x_rdy, input logic x_exec, input logic x_ren, input logic [1:0] x_sid,
    input logic [31:0] x_qty, input logic x_side, input logic [1:0] x_grant,
    input logic [1:0] x_rvalid, input logic [63:0] x_rdata, input logic x_cfg_rdy,
    input logic [63:0] x_recip);
    vec_t v;
    v.ev = ev; v.esid = esid; v.eqty = eqty; v.eside = eside;
    v.rreq = rreq; v.rsid0 = rsid0; v.rsid1 = rsid1; v.cwe = cwe; v.cval = cval;
    v.x_rdy = x_rdy; v.x_exec = x_exec; v.x_ren = x_ren; v.x_sid = x_sid;
    v.x_qty = x_qty; v.x_side = x_side; v.x_grant = x_grant; v.x_rvalid = x_rvalid;
    v.x_rdata = x_rdata; v.x_cfg_rdy = x_cfg_rdy; v.x_recip = x_recip;
    return v;
  endfunction

  task automatic drive_idle();
    ex_if.i_exec_valid    = 1'b0;
    ex_if.i_exec_stock_id = 2'd0;
    ex_if.i_exec_qty      = 32'd0;
    ex_if.i_exec_side     = 1'b0;
    rd_req  = 2'b00;
    rd_sid  = 4'd0;
    cfg_we  = 1'b0;
    cfg_val = 64'd0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " exec_ready"}, ex_if.o_exec_ready, 1);
    chk({tag, " inv_exec"}, inv_exec, 0);
    chk({tag, " inv_ren"}, inv_ren, 0);
    chk({tag, " rd_grant"}, rd_grant, 0);
    chk({tag, " rd_valid"}, rd_valid, 0);
    chk({tag, " rd_data"}, rd_data, 0);
    chk({tag, " recip"}, recip, 0);
    chk({tag, " inv_sid"}, inv_sid, 0);
  endtask

  initial begin
    vec_t v;
    int   next_qty;
    int   sb[$];

    drive_idle();

    //            ev esid eqty   sd rreq   s0    s1   cwe cval | rdy ex ren sid  qty    sd grant rvld  rdata   cfg recip
    vecs.push_back(mk(0, 2'd0, 32'd0, 0, 2'b00, 2'd0, 2'd0, 0, 64'd0, 1, 0, 0, 2'd0, 32'd0, 0, 2'b00, 2'b00, 64'd0, 1, 64'd0));
    vecs.push_back(mk(1, 2'd2, 32'd10, 1, 2'b00, 2'd0, 2'd0, 0, 64'd0, 1, 0, 0, 2'd0, 32'd0, 0, 2'b00, 2'b00, 64'd0, 0, 64'd0));
    vecs.push_back(mk(0, 2'd0, 32'd0, 0, 2'b00, 2'd0, 2'd0, 1, R,     1, 1, 0, 2'd2, 32'd10, 1, 2'b00, 2'b00, 64'd0, 0, 64'd0));
    vecs.push_back(mk(0, 2'd0, 32'd0, 0, 2'b00, 2'd0, 2'd0, 0, 64'd0, 1, 0, 0, 2'd0, 32'd0, 0, 2'b00, 2'b00, 64'd0, 1, 64'd0));
    vecs.push_back(mk(0, 2'd0, 32'd0, 0, 2'b00, 2'd0, 2'd0, 1, R,     1, 0, 0, 2'd0, 32'd0, 0, 2'b00, 2'b00, 64'd0, 1, 64'd0));
    vecs.push_back(mk(0, 2'd0, 32'd0, 0, 2'b00, 2'd0, 2'd0, 0, 64'd0, 1, 0, 0, 2'd0, 32'd0, 0, 2'b00, 2'b00, 64'd0, 1, R));
    vecs.push_back(mk(0, 2'd0, 32'd0, 0, 2'b01, 2'd1, 2'd0, 0, 64'd0, 1, 0, 1, 2'd1, 32'd0, 0, 2'b01, 2'b00, 64'd0, 1, R));
    vecs.push_back(mk(0, 2'd0, 32'd0, 0, 2'b00, 2'd0, 2'd0, 0, 64'd0, 1, 0, 0, 2'd0, 32'd0, 0, 2'b00, 2'b01, C | 1, 1, R));
    vecs.push_back(mk(0, 2'd0, 32'd0, 0, 2'b00, 2'd0, 2'd0, 0, 64'd0, 1, 0, 0, 2'd0, 32'd0, 0, 2'b00, 2'b00, C | 1, 1, R));
    vecs.push_back(mk(1, 2'd2, 32'd5, 0, 2'b00, 2'd0, 2'd0, 1, K1,    1, 0, 0, 2'd0, 32'd0, 0, 2'b00, 2'b00, C | 1, 0, R));
    vecs.push_back(mk(0, 2'd0, 32'd0, 0, 2'b01, 2'd2, 2'd0, 1, KF,    1, 1, 0, 2'd2, 32'd5, 0, 2'b00, 2'b00, C | 1, 0, R));
    vecs.push_back(mk(0, 2'd0, 32'd0, 0, 2'b01, 2'd2, 2'd0, 0, 64'd0, 1, 0, 1, 2'd2, 32'd0, 0, 2'b01, 2'b00, C | 1, 1, R));
    vecs.push_back(mk(0, 2'd0, 32'd0, 0, 2'b00, 2'd0, 2'd0, 0, 64'd0, 1, 0, 0, 2'd0, 32'd0, 0, 2'b00, 2'b01, C | 2, 1, R));
    vecs.push_back(mk(0, 2'd0, 32'd0, 0, 2'b11, 2'd3, 2'd3, 0, 64'd0, 1, 0, 1, 2'd3, 32'd0, 0, 2'b10, 2'b00, C | 2, 1, R));
    vecs.push_back(mk(0, 2'd0, 32'd0, 0, 2'b11, 2'd3, 2'd3, 0, 64'd0, 1, 0, 1, 2'd3, 32'd0, 0, 2'b01, 2'b10, C | 3, 1, R));
    vecs.push_back(mk(0, 2'd0, 32'd0, 0, 2'b11, 2'd3, 2'd3, 0, 64'd0, 1, 0, 1, 2'd3, 32'd0, 0, 2'b10, 2'b01, C | 3, 1, R));
    vecs.push_back(mk(0, 2'd0, 32'd0, 0, 2'b11, 2'd3, 2'd3, 0, 64'd0, 1, 0, 1, 2'd3, 32'd0, 0, 2'b01, 2'b10, C | 3, 1, R));
    vecs.push_back(mk(0, 2'd0, 32'd0, 0, 2'b00, 2'd0, 2'd0, 0, 64'd0, 1, 0, 0, 2'd0, 32'd0, 0, 2'b00, 2'b01, C | 3, 1, R));

    // Power-up reset.
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    #1;
    check_reset_state("por");
    chk("por cfg_ready", cfg_ready, 1);

    // Per-cycle vector table.
    for (int r = 0; r < vecs.size(); r++) begin
      v = vecs[r];
      @(negedge i_clk);
      ex_if.i_exec_valid    = v.ev;
      ex_if.i_exec_stock_id = v.esid;
      ex_if.i_exec_qty      = v.eqty;
      ex_if.i_exec_side     = v.eside;
      rd_req  = v.rreq;
      rd_sid  = {v.rsid1, v.rsid0};
      cfg_we  = v.cwe;
      cfg_val = v.cval;
      #1;
      chk($sformatf("v%0d exec_ready", r), ex_if.o_exec_ready, v.x_rdy);
      chk($sformatf("v%0d inv_exec", r), inv_exec, v.x_exec);
      chk($sformatf("v%0d inv_ren", r), inv_ren, v.x_ren);
      chk($sformatf("v%0d inv_sid", r), inv_sid, v.x_sid);
      if (v.x_exec) begin
        chk($sformatf("v%0d inv_qty", r), inv_qty, v.x_qty);
        chk($sformatf("v%0d inv_side", r), inv_side, v.x_side);
      end
      chk($sformatf("v%0d rd_grant", r), rd_grant, v.x_grant);
      chk($sformatf("v%0d rd_valid", r), rd_valid, v.x_rvalid);
      chk($sformatf("v%0d rd_data", r), rd_data, v.x_rdata);
      chk($sformatf("v%0d cfg_ready", r), cfg_ready, v.x_cfg_rdy);
      chk($sformatf("v%0d recip", r), recip, v.x_recip);
    end

    // Starvation and fill: continuous stock-0 pushes while reader 1 waits on
    // stock 3. Reads land every 5th cycle (4 writes between), the queue
    // gains one entry per read and so becomes full at cycle 16 and 21.
    next_qty = 100;
    for (int k = 0; k < 26; k++) begin
      logic exp_read;
      logic exp_rdy;
      @(negedge i_clk);
      ex_if.i_exec_valid    = 1'b1;
      ex_if.i_exec_stock_id = 2'd0;
      ex_if.i_exec_qty      = 32'(next_qty);
      ex_if.i_exec_side     = 1'b0;
      rd_req = 2'b10;
      rd_sid = {2'd3, 2'd0};
      cfg_we = 1'b0;
      #1;
      exp_read = (k % 5 == 0);
      exp_rdy  = !(k >= 16 && k % 5 == 1);
      chk($sformatf("starve k%0d exec_ready", k), ex_if.o_exec_ready, exp_rdy);
      chk($sformatf("starve k%0d rd_grant", k), rd_grant, exp_read ? 2'b10 : 2'b00);
      chk($sformatf("starve k%0d inv_exec", k), inv_exec, !exp_read);
      chk($sformatf("starve k%0d inv_sid", k), inv_sid, exp_read ? 2'd3 : 2'd0);
      if (inv_exec) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL starve k%0d order: write with qty %0d but nothing queued", k, inv_qty);
        end else begin
          chk($sformatf("starve k%0d order", k), inv_qty, 64'(sb.pop_front()));
        end
      end
      if (ex_if.o_exec_ready) begin
        sb.push_back(next_qty);
        next_qty++;
      end
    end

    // Reset in mid-operation: queue and configuration are dropped.
    @(negedge i_clk);
    drive_idle();
    i_reset_n = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    #1;
    check_reset_state("midrst");
    @(negedge i_clk);
    #1;
    chk("midrst queue dropped", inv_exec, 0);
    chk("midrst cfg_ready", cfg_ready, 1);

    // Round-robin from a freshly reset pointer.
    for (int j = 0; j < 4; j++) begin
      @(negedge i_clk);
      rd_req = 2'b11;
      rd_sid = {2'd1, 2'd1};
      #1;
      chk($sformatf("rr%0d rd_grant", j), rd_grant, (j % 2 == 0) ? 2'b01 : 2'b10);
    end
    @(negedge i_clk);
    drive_idle();
    #1;
    chk("rr tail rd_valid", rd_valid, 2'b10);
    chk("rr tail rd_data", rd_data, C | 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
